// File: rtl/game_msg_sequencer.sv
// Zero-stopwatch game controller: sequences game phases, drives the seg7 message select,
// controls the stopwatch and judges the stop. Optional timeout: GAME_SEQ_TIMEOUT_EN.
package game_msg_pkg;
    typedef enum logic [2:0] {
        EMPTY_MSG     = 3'd0,
        WELCOME_MSG   = 3'd1,
        READY_MSG     = 3'd2,
        STOPWATCH_MSG = 3'd3,
        WIN_MSG       = 3'd4
    } msg_t;
endpackage

module game_msg_sequencer
    import game_msg_pkg::*;
#(
    parameter int WELCOME_TICKS = 2000,
    parameter int WIN_TICKS     = 3000,
    parameter int LOSE_TICKS    = 3000,
    parameter int WIN_WINDOW    = 0,
    parameter int MAX_SEC       = 99
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       btn_i,
    input  logic [6:0] sw_cs_i,
    input  logic [6:0] sw_sec_i,
    output msg_t       msg_o,
    output logic       sw_clear_o,
    output logic       sw_run_o,
    output logic       win_o,
    output logic       busy_o
);

    localparam int MAX_AB    = (WELCOME_TICKS > WIN_TICKS) ? WELCOME_TICKS : WIN_TICKS;
    localparam int MAX_TICKS = (MAX_AB > LOSE_TICKS) ? MAX_AB : LOSE_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);

    // Terminal values are one below the duration: the final tick itself triggers the exit.
    localparam logic [CNT_W-1:0] WELCOME_LAST = CNT_W'(WELCOME_TICKS - 1);
    localparam logic [CNT_W-1:0] WIN_LAST     = CNT_W'(WIN_TICKS - 1);
    localparam logic [CNT_W-1:0] LOSE_LAST    = CNT_W'(LOSE_TICKS - 1);
    localparam logic [6:0]       WIN_LO       = 7'(WIN_WINDOW);
    localparam logic [6:0]       WIN_HI       = 7'(100 - WIN_WINDOW);

    typedef enum logic [2:0] {
        S_EMPTY,
        S_WELCOME,
        S_READY,
        S_RUN,
        S_JUDGE,
        S_WIN,
        S_LOSE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_win_hit;
    logic             w_timeout;
    msg_t             w_msg;
    logic             w_clear;
    logic             w_run;
    logic             w_win;
    logic             w_busy;

    // A zero window must not open the upper side, otherwise cs>=100 would count as a win.
    assign w_win_hit = (sw_cs_i <= WIN_LO) || ((WIN_WINDOW != 0) && (sw_cs_i >= WIN_HI));

`ifdef GAME_SEQ_TIMEOUT_EN
    assign w_timeout = (sw_sec_i == 7'(MAX_SEC)) && (sw_cs_i == 7'd99);
`else
    logic w_unused_sec;
    assign w_unused_sec = ^sw_sec_i;
    assign w_timeout    = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_EMPTY:   if (btn_i) w_next = S_WELCOME;
            S_WELCOME: if (btn_i || (tick_i && (r_cnt == WELCOME_LAST))) w_next = S_READY;
            S_READY:   if (btn_i) w_next = S_RUN;
            S_RUN: begin
                if (btn_i)          w_next = S_JUDGE;
                else if (w_timeout) w_next = S_LOSE;
            end
            S_JUDGE:   w_next = w_win_hit ? S_WIN : S_LOSE;
            S_WIN:     if (tick_i && (r_cnt == WIN_LAST)) w_next = S_READY;
            S_LOSE:    if (tick_i && (r_cnt == LOSE_LAST)) w_next = S_READY;
            default:   w_next = S_EMPTY;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with r_state.
    always_comb begin
        w_msg = EMPTY_MSG;
        case (w_next)
            S_WELCOME:              w_msg = WELCOME_MSG;
            S_READY:                w_msg = READY_MSG;
            S_RUN, S_JUDGE, S_LOSE: w_msg = STOPWATCH_MSG;
            S_WIN:                  w_msg = WIN_MSG;
            default:                w_msg = EMPTY_MSG;
        endcase
        w_clear = (w_next == S_READY) && (r_state != S_READY);
        w_run   = (w_next == S_RUN);
        w_win   = (r_state == S_JUDGE) && (w_next == S_WIN);
        w_busy  = (w_next != S_EMPTY) && (w_next != S_READY);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_EMPTY;
            r_cnt      <= '0;
            msg_o      <= EMPTY_MSG;
            sw_clear_o <= 1'b0;
            sw_run_o   <= 1'b0;
            win_o      <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            r_state    <= w_next;
            msg_o      <= w_msg;
            sw_clear_o <= w_clear;
            sw_run_o   <= w_run;
            win_o      <= w_win;
            busy_o     <= w_busy;
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (tick_i) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_game_msg_sequencer.sv
// Directed bench for game_msg_sequencer; expectations go through a scoreboard queue.
// Build with GAME_SEQ_TIMEOUT_EN defined to cover the timeout path.
module tb_game_msg_sequencer;
    import game_msg_pkg::*;

    typedef struct {
        msg_t  msg;
        logic  run;
        logic  clr;
        logic  win;
        logic  busy;
        string tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       btn;
    logic [6:0] csIn;
    logic [6:0] secIn;
    msg_t       msgOut;
    logic       clrOut;
    logic       runOut;
    logic       winOut;
    logic       busyOut;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    game_msg_sequencer #(
        .WELCOME_TICKS(4),
        .WIN_TICKS    (3),
        .LOSE_TICKS   (5),
        .WIN_WINDOW   (2),
        .MAX_SEC      (2)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .tick_i    (tick),
        .btn_i     (btn),
        .sw_cs_i   (csIn),
        .sw_sec_i  (secIn),
        .msg_o     (msgOut),
        .sw_clear_o(clrOut),
        .sw_run_o  (runOut),
        .win_o     (winOut),
        .busy_o    (busyOut)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input string field,
                            input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        checks++;
        assert (expQ.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkVal(e.tag, "msg",   msgOut,          e.msg);
            checkVal(e.tag, "run",   {2'b0, runOut},  {2'b0, e.run});
            checkVal(e.tag, "clear", {2'b0, clrOut},  {2'b0, e.clr});
            checkVal(e.tag, "win",   {2'b0, winOut},  {2'b0, e.win});
            checkVal(e.tag, "busy",  {2'b0, busyOut}, {2'b0, e.busy});
        end
    endtask

    // Drive one cycle of inputs, queue the expected registered outputs, sample after the edge.
    task automatic applyStimulus(input logic r, input logic b, input logic t, input msg_t m,
                                 input logic run, input logic clr, input logic win,
                                 input logic busy, input string tag);
        exp_t e;
        rst  = r;
        btn  = b;
        tick = t;
        e.msg = m; e.run = run; e.clr = clr; e.win = win; e.busy = busy; e.tag = tag;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        btn  = 1'b0;
        tick = 1'b0;
        checkOutput();
    endtask

    initial begin
        rst = 1'b1; btn = 1'b0; tick = 1'b0; csIn = 7'd0; secIn = 7'd0;

        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, EMPTY_MSG, 0, 0, 0, 0, "reset_hold");
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, EMPTY_MSG, 0, 0, 0, 0, "idle_empty");
        applyStimulus(0, 0, 1, EMPTY_MSG, 0, 0, 0, 0, "tick_in_empty");

        // Welcome timing out on the fourth tick
        applyStimulus(0, 1, 0, WELCOME_MSG, 0, 0, 0, 1, "enter_welcome");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, WELCOME_MSG, 0, 0, 0, 1, "welcome_tick");
        applyStimulus(0, 0, 1, READY_MSG, 0, 1, 0, 0, "welcome_timeout");
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, READY_MSG, 0, 0, 0, 0, "ready_clear_once");

        // Early press after two ticks
        applyStimulus(1, 0, 0, EMPTY_MSG, 0, 0, 0, 0, "reset_from_ready");
        applyStimulus(0, 1, 0, WELCOME_MSG, 0, 0, 0, 1, "enter_welcome2");
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 1, WELCOME_MSG, 0, 0, 0, 1, "welcome2_tick");
        applyStimulus(0, 1, 0, READY_MSG, 0, 1, 0, 0, "welcome_early_btn");
        applyStimulus(0, 0, 0, READY_MSG, 0, 0, 0, 0, "ready2_idle");

        // Press together with the final welcome tick
        applyStimulus(1, 0, 0, EMPTY_MSG, 0, 0, 0, 0, "reset_again");
        applyStimulus(0, 1, 0, WELCOME_MSG, 0, 0, 0, 1, "enter_welcome3");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, WELCOME_MSG, 0, 0, 0, 1, "welcome3_tick");
        applyStimulus(0, 1, 1, READY_MSG, 0, 1, 0, 0, "btn_on_last_tick");
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, READY_MSG, 0, 0, 0, 0, "single_ready_entry");

        // Exact zero stop, press ignored during WIN
        csIn = 7'd0;
        applyStimulus(0, 1, 0, STOPWATCH_MSG, 1, 0, 0, 1, "start_run");
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, STOPWATCH_MSG, 1, 0, 0, 1, "running");
        applyStimulus(0, 1, 0, STOPWATCH_MSG, 0, 0, 0, 1, "stop_press");
        applyStimulus(0, 0, 0, WIN_MSG, 0, 0, 1, 1, "judge_win_cs0");
        applyStimulus(0, 0, 1, WIN_MSG, 0, 0, 0, 1, "win_tick1");
        applyStimulus(0, 1, 0, WIN_MSG, 0, 0, 0, 1, "win_btn_ignored");
        applyStimulus(0, 0, 1, WIN_MSG, 0, 0, 0, 1, "win_tick2");
        applyStimulus(0, 0, 0, WIN_MSG, 0, 0, 0, 1, "win_idle");
        applyStimulus(0, 0, 1, READY_MSG, 0, 1, 0, 0, "win_done");

        // Upper window edge; press lands on the clear-pulse cycle
        csIn = 7'd98;
        applyStimulus(0, 1, 0, STOPWATCH_MSG, 1, 0, 0, 1, "btn_with_clear");
        applyStimulus(0, 1, 0, STOPWATCH_MSG, 0, 0, 0, 1, "stop_98");
        applyStimulus(0, 0, 0, WIN_MSG, 0, 0, 1, 1, "judge_win_cs98");
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 1, WIN_MSG, 0, 0, 0, 1, "win98_tick");
        applyStimulus(0, 0, 1, READY_MSG, 0, 1, 0, 0, "win98_done");

        // Just outside the window: lose, press ignored during LOSE
        csIn = 7'd97;
        applyStimulus(0, 0, 0, READY_MSG, 0, 0, 0, 0, "ready_idle");
        applyStimulus(0, 1, 0, STOPWATCH_MSG, 1, 0, 0, 1, "start_run97");
        applyStimulus(0, 1, 0, STOPWATCH_MSG, 0, 0, 0, 1, "stop_97");
        applyStimulus(0, 0, 0, STOPWATCH_MSG, 0, 0, 0, 1, "judge_lose_cs97");
        applyStimulus(0, 0, 1, STOPWATCH_MSG, 0, 0, 0, 1, "lose_tick1");
        applyStimulus(0, 1, 0, STOPWATCH_MSG, 0, 0, 0, 1, "lose_btn_ignored");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, STOPWATCH_MSG, 0, 0, 0, 1, "lose_tick");
        applyStimulus(0, 0, 1, READY_MSG, 0, 1, 0, 0, "lose_done");

        // Lower window edge
        csIn = 7'd2;
        applyStimulus(0, 1, 0, STOPWATCH_MSG, 1, 0, 0, 1, "start_run2");
        applyStimulus(0, 1, 0, STOPWATCH_MSG, 0, 0, 0, 1, "stop_2");
        applyStimulus(0, 0, 0, WIN_MSG, 0, 0, 1, 1, "judge_win_cs2");
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 1, WIN_MSG, 0, 0, 0, 1, "win2_tick");
        applyStimulus(0, 0, 1, READY_MSG, 0, 1, 0, 0, "win2_done");

        // Timeout condition while running
        csIn = 7'd10; secIn = 7'd0;
        applyStimulus(0, 1, 0, STOPWATCH_MSG, 1, 0, 0, 1, "start_run_to");
        csIn = 7'd99; secIn = 7'd2;
`ifdef GAME_SEQ_TIMEOUT_EN
        applyStimulus(0, 0, 0, STOPWATCH_MSG, 0, 0, 0, 1, "timeout_lose");
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, STOPWATCH_MSG, 0, 0, 0, 1, "timeout_lose_tick");
        applyStimulus(0, 0, 1, READY_MSG, 0, 1, 0, 0, "timeout_lose_done");
`else
        applyStimulus(0, 0, 0, STOPWATCH_MSG, 1, 0, 0, 1, "no_timeout_run");
        applyStimulus(0, 0, 0, STOPWATCH_MSG, 1, 0, 0, 1, "no_timeout_run2");
        applyStimulus(0, 1, 0, STOPWATCH_MSG, 0, 0, 0, 1, "stop_99");
        applyStimulus(0, 0, 0, WIN_MSG, 0, 0, 1, 1, "judge_win_cs99");
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 1, WIN_MSG, 0, 0, 0, 1, "win99_tick");
        applyStimulus(0, 0, 1, READY_MSG, 0, 1, 0, 0, "win99_done");
`endif

        // Press coinciding with the timeout condition takes the judge path
        applyStimulus(0, 1, 0, STOPWATCH_MSG, 1, 0, 0, 1, "start_run_btn_to");
        applyStimulus(0, 1, 0, STOPWATCH_MSG, 0, 0, 0, 1, "btn_beats_timeout");
        applyStimulus(0, 0, 0, WIN_MSG, 0, 0, 1, 1, "judge_after_btn_to");
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 1, WIN_MSG, 0, 0, 0, 1, "win_to_tick");
        applyStimulus(0, 0, 1, READY_MSG, 0, 1, 0, 0, "win_to_done");

        // Reset aborts a running game without a clear pulse
        csIn = 7'd40; secIn = 7'd0;
        applyStimulus(0, 1, 0, STOPWATCH_MSG, 1, 0, 0, 1, "start_run_rst");
        applyStimulus(1, 0, 0, EMPTY_MSG, 0, 0, 0, 0, "reset_in_run");
        applyStimulus(0, 0, 0, EMPTY_MSG, 0, 0, 0, 0, "after_reset_idle");

        checks++;
        assert (expQ.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", expQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_msg_sequencer.md
Name: game_msg_sequencer

Overview:
- Top-level game controller for the zero-stopwatch game: sequences the game phases and drives the message selector of the 7-segment multiplexer.
- Also controls the stopwatch counter (clear/run) and judges the stop result.
- Sits between the debounced button / 1 ms tick sources and the stopwatch + seg7 mux datapath.

Parameters:
- WELCOME_TICKS, 2000, tick_i pulses WELCOME_MSG is shown before auto-advancing to READY.
- WIN_TICKS, 3000, tick_i pulses WIN_MSG is shown.
- LOSE_TICKS, 3000, tick_i pulses the frozen stopwatch value is shown after a miss.
- WIN_WINDOW, 0, tolerance in centiseconds around .00; legal range 0..49.
- MAX_SEC, 99, timeout limit in seconds (used only with the optional feature).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- tick_i  in  1  one-cycle 1 ms strobe
- btn_i  in  1  one-cycle debounced press pulse
- sw_cs_i  in  7  stopwatch centiseconds, 0..99
- sw_sec_i  in  7  stopwatch seconds, 0..99
- msg_o  out  msg_t  message select to the seg7 mux
- sw_clear_o  out  1  one-cycle stopwatch clear pulse
- sw_run_o  out  1  stopwatch count enable
- win_o  out  1  one-cycle pulse on a judged win
- busy_o  out  1  high whenever state is not S_EMPTY or S_READY

Behaviour:
- Registered Moore FSM. All outputs are registered and change one cycle after the triggering input.
- Reset (sync, rst_i high at a clock edge): state S_EMPTY, msg_o=EMPTY_MSG, sw_clear_o=0, sw_run_o=0, win_o=0, busy_o=0, tick counter=0.
- Reset has priority over every other input. Asserting it mid-game aborts to S_EMPTY on the next edge and does not emit a clear pulse.
- Tick counter width is $clog2(max(WELCOME_TICKS,WIN_TICKS,LOSE_TICKS)+1). It is zeroed on every state entry and increments on tick_i.
- S_EMPTY: msg_o=EMPTY_MSG. On btn_i go to S_WELCOME.
- S_WELCOME: msg_o=WELCOME_MSG.
  - btn_i goes to S_READY early.
  - Otherwise, on the tick that makes count==WELCOME_TICKS, go to S_READY.
  - btn_i and the final tick in the same cycle: go to S_READY once.
- S_READY: msg_o=READY_MSG. sw_clear_o=1 for exactly the first cycle after entry. On btn_i go to S_RUN.
- A btn_i in the same cycle as the S_READY clear pulse is accepted: the clear pulse still occurs, then S_RUN.
- S_RUN: msg_o=STOPWATCH_MSG, sw_run_o=1. On btn_i go to S_JUDGE; sw_run_o drops in the same edge.
- S_JUDGE (1 cycle): sw_run_o=0, msg_o=STOPWATCH_MSG.
  - Sample sw_cs_i. Win if sw_cs_i <= WIN_WINDOW or sw_cs_i >= 100-WIN_WINDOW.
  - With WIN_WINDOW=0 the win condition is exactly cs==0.
  - Win: go to S_WIN and pulse win_o for 1 cycle. Miss: go to S_LOSE.
- S_WIN: msg_o=WIN_MSG. After WIN_TICKS ticks go to S_READY. btn_i is ignored.
- S_LOSE: msg_o=STOPWATCH_MSG with sw_run_o=0, so the stopped value stays visible. After LOSE_TICKS ticks go to S_READY. btn_i is ignored.
- tick_i and btn_i pulses that arrive while no transition consumes them are dropped, not queued.
- A msg_o value outside the five enumerators is never produced.

Optional Feature:
- Macro: GAME_SEQ_TIMEOUT_EN.
- Defined: in S_RUN, when sw_sec_i==MAX_SEC and sw_cs_i==99, the FSM goes to S_LOSE on the next edge without a press, and sw_run_o drops in that edge.
  - If btn_i arrives in the same cycle as the timeout, btn_i wins and the FSM goes to S_JUDGE.
- Not defined: no timeout; S_RUN leaves only on btn_i. sw_sec_i is unused (tie off, no lint waiver needed beyond unused input).

Test Plan:
- Reset, then hold 5 cycles -> msg_o=EMPTY_MSG, sw_run_o=0, sw_clear_o=0, busy_o=0. Assert rst_i while in S_RUN -> next edge msg_o=EMPTY_MSG, sw_run_o=0.
- WELCOME_TICKS=4: btn_i in S_EMPTY, then 4 tick_i -> WELCOME_MSG during ticks 1..3, READY_MSG after the 4th, then exactly one sw_clear_o cycle. Repeat with btn_i after 2 ticks -> READY_MSG after the press.
- WIN_WINDOW=0, WIN_TICKS=3: READY -> btn -> sw_run_o=1 and STOPWATCH_MSG; drive sw_cs_i=0, press btn -> one win_o pulse, WIN_MSG for 3 ticks, then READY_MSG with one clear pulse.
- WIN_WINDOW=2: stop with sw_cs_i=98 -> win; sw_cs_i=97 -> S_LOSE (STOPWATCH_MSG, sw_run_o=0, no win_o) for LOSE_TICKS, then READY_MSG.
- Simultaneous events: btn_i on the final WELCOME tick -> single entry into READY. btn_i during S_WIN and S_LOSE -> ignored, durations unchanged.
- With GAME_SEQ_TIMEOUT_EN and MAX_SEC=2: drive sw_sec_i=2, sw_cs_i=99 in S_RUN -> S_LOSE with no win_o. Repeat with btn_i in the same cycle -> S_JUDGE path taken. Without the macro -> stays in S_RUN.
